// File: rtl/food_spawner.sv
// Turns the free-running random word into a legal food cell, checking snake occupancy through a 1-cycle query port.
// Optional linear fallback search after MAX_TRIES random misses: define FOOD_FALLBACK_SCAN_EN.
module food_spawner #(
    parameter int GRID_W    = 30,
    parameter int GRID_H    = 15,
    parameter int X_BITS    = 5,
    parameter int Y_BITS    = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        rand_num,
    input  logic              spawn_req,
    output logic              busy,
    output logic              occ_rd,
    output logic [8:0]        occ_addr,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              spawn_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAND,
        S_WAIT
`ifdef FOOD_FALLBACK_SCAN_EN
        , S_SCAN_Q,
        S_SCAN_W
`endif
    } state_t;

    state_t            r_state;
    logic [8:0]        r_cand;
    logic [7:0]        r_tries;
    logic              r_ph;
    logic              r_occ_rd;
    logic [8:0]        r_occ_addr;
    logic [X_BITS-1:0] r_food_x;
    logic [Y_BITS-1:0] r_food_y;
    logic              r_food_valid;
    logic              r_spawn_fail;

    logic [X_BITS-1:0] w_cand_x;
    logic [Y_BITS-1:0] w_cand_y;
    logic              w_in_bounds;
    logic [8:0]        w_cand_addr;
    logic [7:0]        w_tries_inc;
    logic              w_exhaust;

    assign w_cand_x    = r_cand[X_BITS-1:0];
    assign w_cand_y    = r_cand[8:X_BITS];
    assign w_in_bounds = (int'(w_cand_x) < GRID_W) && (int'(w_cand_y) < GRID_H);
    assign w_cand_addr = 9'(int'(w_cand_y) * GRID_W + int'(w_cand_x));
    // The try counter saturates so a large MAX_TRIES can never wrap past the limit.
    assign w_tries_inc = (r_tries == 8'hFF) ? 8'hFF : r_tries + 8'd1;
    assign w_exhaust   = (w_tries_inc >= 8'(MAX_TRIES));

`ifdef FOOD_FALLBACK_SCAN_EN
    localparam int CELLS = GRID_W * GRID_H;
    localparam int PW    = 9 + X_BITS + Y_BITS;

    logic              r_last_vld;
    logic [8:0]        r_last_addr;
    logic [X_BITS-1:0] r_last_x;
    logic [Y_BITS-1:0] r_last_y;
    logic [8:0]        r_idx;
    logic [X_BITS-1:0] r_sx;
    logic [Y_BITS-1:0] r_sy;
    logic [8:0]        r_scan_cnt;

    logic [8:0]        w_start_idx;
    logic [X_BITS-1:0] w_start_x;
    logic [Y_BITS-1:0] w_start_y;
    logic [8:0]        w_step_idx;
    logic [X_BITS-1:0] w_step_x;
    logic [Y_BITS-1:0] w_step_y;

    // The scan index travels with its (x,y) so the free cell is known without a divider.
    function automatic logic [PW-1:0] next_cell(input logic [8:0]        idx,
                                                input logic [X_BITS-1:0] x,
                                                input logic [Y_BITS-1:0] y);
        if (int'(idx) == CELLS - 1)
            return '0;
        else if (int'(x) == GRID_W - 1)
            return {idx + 9'd1, {X_BITS{1'b0}}, y + Y_BITS'(1)};
        else
            return {idx + 9'd1, x + X_BITS'(1), y};
    endfunction

    assign {w_start_idx, w_start_x, w_start_y} =
        r_last_vld ? next_cell(r_last_addr, r_last_x, r_last_y)
                   : next_cell(9'd0, {X_BITS{1'b0}}, {Y_BITS{1'b0}});
    assign {w_step_idx, w_step_x, w_step_y} = next_cell(r_idx, r_sx, r_sy);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cand       <= '0;
            r_tries      <= '0;
            r_ph         <= 1'b0;
            r_occ_rd     <= 1'b0;
            r_occ_addr   <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
            r_spawn_fail <= 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
            r_last_vld   <= 1'b0;
            r_last_addr  <= '0;
            r_last_x     <= '0;
            r_last_y     <= '0;
            r_idx        <= '0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_scan_cnt   <= '0;
`endif
        end else begin
            r_occ_rd     <= 1'b0;
            r_occ_addr   <= '0;
            r_spawn_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (spawn_req) begin
                        r_cand       <= rand_num;
                        r_tries      <= '0;
                        r_food_valid <= 1'b0;
                        r_state      <= S_CAND;
`ifdef FOOD_FALLBACK_SCAN_EN
                        r_last_vld   <= 1'b0;
`endif
                    end
                end
                S_CAND: begin
                    if (w_in_bounds) begin
                        r_occ_rd   <= 1'b1;
                        r_occ_addr <= w_cand_addr;
                        r_ph       <= 1'b0;
                        r_state    <= S_WAIT;
`ifdef FOOD_FALLBACK_SCAN_EN
                        r_last_vld  <= 1'b1;
                        r_last_addr <= w_cand_addr;
                        r_last_x    <= w_cand_x;
                        r_last_y    <= w_cand_y;
`endif
                    end else begin
                        r_tries <= w_tries_inc;
                        if (w_exhaust) begin
`ifdef FOOD_FALLBACK_SCAN_EN
                            r_idx      <= w_start_idx;
                            r_sx       <= w_start_x;
                            r_sy       <= w_start_y;
                            r_scan_cnt <= '0;
                            r_occ_rd   <= 1'b1;
                            r_occ_addr <= w_start_idx;
                            r_state    <= S_SCAN_Q;
`else
                            r_spawn_fail <= 1'b1;
                            r_state      <= S_IDLE;
`endif
                        end else begin
                            r_cand <= rand_num;
                        end
                    end
                end
                S_WAIT: begin
                    // First WAIT cycle covers the query in flight; the second samples the answer.
                    if (!r_ph) begin
                        r_ph <= 1'b1;
                    end else if (!occ_hit) begin
                        r_food_x     <= w_cand_x;
                        r_food_y     <= w_cand_y;
                        r_food_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_tries <= w_tries_inc;
                        if (w_exhaust) begin
`ifdef FOOD_FALLBACK_SCAN_EN
                            r_idx      <= w_start_idx;
                            r_sx       <= w_start_x;
                            r_sy       <= w_start_y;
                            r_scan_cnt <= '0;
                            r_occ_rd   <= 1'b1;
                            r_occ_addr <= w_start_idx;
                            r_state    <= S_SCAN_Q;
`else
                            r_spawn_fail <= 1'b1;
                            r_state      <= S_IDLE;
`endif
                        end else begin
                            r_cand  <= rand_num;
                            r_state <= S_CAND;
                        end
                    end
                end
`ifdef FOOD_FALLBACK_SCAN_EN
                S_SCAN_Q: begin
                    r_state <= S_SCAN_W;
                end
                S_SCAN_W: begin
                    if (!occ_hit) begin
                        r_food_x     <= r_sx;
                        r_food_y     <= r_sy;
                        r_food_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (int'(r_scan_cnt) == CELLS - 1) begin
                        r_spawn_fail <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 9'd1;
                        r_idx      <= w_step_idx;
                        r_sx       <= w_step_x;
                        r_sy       <= w_step_y;
                        r_occ_rd   <= 1'b1;
                        r_occ_addr <= w_step_idx;
                        r_state    <= S_SCAN_Q;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign occ_rd     = r_occ_rd;
    assign occ_addr   = r_occ_addr;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign spawn_fail = r_spawn_fail;

endmodule

// File: tb/tb_food_spawner.sv
// Self-checking bench for food_spawner: randomized candidates and occupancy against a cycle-budget reference model.
module tb_food_spawner;
    localparam int W  = 30;
    localparam int H  = 15;
    localparam int MT = 8;
    localparam int N  = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] rand_num = '0;
    logic       spawn_req = 1'b0;
    logic       occ_hit = 1'b0;
    logic       busy, occ_rd, food_valid, spawn_fail;
    logic [8:0] occ_addr;
    logic [4:0] food_x;
    logic [3:0] food_y;

    food_spawner dut (
        .clk(clk), .rst_n(rst_n), .rand_num(rand_num), .spawn_req(spawn_req),
        .busy(busy), .occ_rd(occ_rd), .occ_addr(occ_addr), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .spawn_fail(spawn_fail)
    );

    always #5 clk = ~clk;

    bit         occ_map[N];
    logic [8:0] seq[64];
    int         checks = 0;
    int         failures = 0;
    int         rd_q[$];
    int         exp_q[$];
    int         n_fail_pulse = 0;
    int         prot_err = 0;
    logic       prev_rd = 1'b0;

    // Body-map model: answers one cycle after the query strobe.
    always @(posedge clk)
        occ_hit <= (occ_rd && int'(occ_addr) < N) ? occ_map[occ_addr] : 1'b0;

    always @(negedge clk) begin
        if (occ_rd === 1'b1) rd_q.push_back(int'(occ_addr));
        if (occ_rd === 1'b0 && occ_addr !== 9'd0) prot_err++;
        if (occ_rd === 1'b1 && prev_rd === 1'b1) prot_err++;
        prev_rd = occ_rd;
        if (spawn_fail === 1'b1) n_fail_pulse++;
    end

    task automatic fill_map(input int pct);
        for (int i = 0; i < N; i++) occ_map[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic rand_seq();
        for (int i = 0; i < 64; i++) seq[i] = 9'($urandom_range(0, 511));
    endtask

    // Each in-bounds candidate costs three edges, each out-of-bounds one costs one;
    // each fallback cell costs two.
    task automatic model_spawn(output int e_edge, output bit e_fail, output int e_x, output int e_y);
        int t, tries, last, cx, cy, a, idx, base;
        bit done;
        t = 0; tries = 0; last = -1; done = 0;
        e_edge = 0; e_fail = 0; e_x = 0; e_y = 0;
        exp_q = {};
        while (!done) begin
            cx = int'(seq[t]) % 32;
            cy = int'(seq[t]) / 32;
            tries++;
            if (cx < W && cy < H) begin
                a = cy * W + cx;
                exp_q.push_back(a);
                last = a;
                if (!occ_map[a]) begin
                    done = 1; e_edge = t + 3; e_x = cx; e_y = cy;
                end else if (tries == MT) begin
                    done = 1; e_edge = t + 3; e_fail = 1;
                end else t += 3;
            end else if (tries == MT) begin
                done = 1; e_edge = t + 1; e_fail = 1;
            end else t += 1;
        end
`ifdef FOOD_FALLBACK_SCAN_EN
        if (e_fail) begin
            idx  = ((last < 0 ? 0 : last) + 1) % N;
            base = e_edge;
            e_edge = base + 2 * N;
            done = 0;
            for (int j = 0; j < N; j++) begin
                if (!done) begin
                    a = (idx + j) % N;
                    exp_q.push_back(a);
                    if (!occ_map[a]) begin
                        done = 1; e_fail = 0; e_edge = base + 2 + 2 * j;
                        e_x = a % W; e_y = a / W;
                    end
                end
            end
        end
`endif
    endtask

    task automatic drive_spawn(input int limit, input bit hold_req,
                               output int d_edge, output bit got_fail, output bit hold_ok);
        logic [4:0] px;
        logic [3:0] py;
        px = food_x; py = food_y;
        hold_ok = 1; d_edge = -1; got_fail = 0;
        @(negedge clk);
        rd_q = {}; n_fail_pulse = 0;
        spawn_req = 1'b1;
        rand_num = seq[0];
        for (int k = 0; k < limit && d_edge < 0; k++) begin
            @(posedge clk); #1;
            spawn_req = hold_req && (k < 3);
            rand_num = (k + 1 < 64) ? seq[k+1] : 9'($urandom_range(0, 511));
            if (food_valid === 1'b1) d_edge = k;
            else if (spawn_fail === 1'b1) begin d_edge = k; got_fail = 1; end
            else if (food_x !== px || food_y !== py || busy !== 1'b1) hold_ok = 0;
        end
        spawn_req = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || occ_rd !== 1'b0 || occ_addr !== 9'd0) begin
            failures++; $display("FAIL reset_ctrl busy=%b occ_rd=%b occ_addr=%0d want 0/0/0", busy, occ_rd, occ_addr); end
        checks++; if (food_x !== 5'd0 || food_y !== 4'd0 || food_valid !== 1'b0 || spawn_fail !== 1'b0) begin
            failures++; $display("FAIL reset_food x=%0d y=%0d v=%b f=%b want all 0", food_x, food_y, food_valid, spawn_fail); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || food_valid !== 1'b0 || occ_rd !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b v=%b occ_rd=%b want 0", busy, food_valid, occ_rd); end
        prot_err = 0;
    endtask

    task automatic test_first_try();
        int de; bit gf, ho;
        for (int i = 0; i < 64; i++) seq[i] = 9'h0A3;
        fill_map(0);
        drive_spawn(40, 0, de, gf, ho);
        checks++; if (rd_q.size() != 1 || rd_q[0] != 153) begin
            failures++; $display("FAIL first_addr strobes=%0d addr=%0d want 1 strobe at 153", rd_q.size(), rd_q.size() ? rd_q[0] : -1); end
        checks++; if (de != 3 || gf) begin
            failures++; $display("FAIL first_latency edge=%0d fail=%0d want edge 3 no fail", de, gf); end
        checks++; if (food_x !== 5'd3 || food_y !== 4'd5 || food_valid !== 1'b1) begin
            failures++; $display("FAIL first_pos x=%0d y=%0d v=%b want 3,5,1", food_x, food_y, food_valid); end
    endtask

    task automatic test_oob_retry();
        int de; bit gf, ho;
        for (int i = 0; i < 64; i++) seq[i] = 9'h0A3;
        seq[0] = 9'h01F;
        fill_map(0);
        drive_spawn(40, 0, de, gf, ho);
        checks++; if (rd_q.size() != 1 || rd_q[0] != 153) begin
            failures++; $display("FAIL oob_addr strobes=%0d want 1 strobe at 153", rd_q.size()); end
        checks++; if (de != 4 || food_x !== 5'd3 || food_y !== 4'd5 || food_valid !== 1'b1) begin
            failures++; $display("FAIL oob_result edge=%0d x=%0d y=%0d v=%b want 4,3,5,1", de, food_x, food_y, food_valid); end
        checks++; if (!ho) begin
            failures++; $display("FAIL oob_hold food moved or busy dropped during request, want held"); end
    endtask

    task automatic test_exhaust();
        int de, ee, ex, ey; bit gf, ef, ho;
        rand_seq();
        for (int i = 0; i < N; i++) occ_map[i] = 1'b1;
        model_spawn(ee, ef, ex, ey);
        drive_spawn(1200, 0, de, gf, ho);
        checks++; if (rd_q != exp_q) begin
            failures++; $display("FAIL exhaust_strobes got=%0d want=%0d strobes", rd_q.size(), exp_q.size()); end
        checks++; if (!gf || de != ee) begin
            failures++; $display("FAIL exhaust_fail fail=%0d edge=%0d want fail at edge %0d", gf, de, ee); end
        @(posedge clk); #1;
        checks++; if (n_fail_pulse != 1 || spawn_fail !== 1'b0 || food_valid !== 1'b0) begin
            failures++; $display("FAIL exhaust_pulse cycles=%0d now=%b v=%b want 1 cycle, 0, 0", n_fail_pulse, spawn_fail, food_valid); end
        checks++; if (food_x !== 5'd3 || food_y !== 4'd5) begin
            failures++; $display("FAIL exhaust_hold x=%0d y=%0d want 3,5", food_x, food_y); end
    endtask

`ifdef FOOD_FALLBACK_SCAN_EN
    task automatic test_fallback();
        int de; bit gf, ho;
        rand_seq();
        for (int i = 0; i < N; i++) occ_map[i] = (i != 200);
        drive_spawn(1200, 0, de, gf, ho);
        checks++; if (gf || n_fail_pulse != 0 || food_x !== 5'd20 || food_y !== 4'd6 || food_valid !== 1'b1) begin
            failures++; $display("FAIL fallback_pos x=%0d y=%0d v=%b fail=%0d want 20,6,1,0", food_x, food_y, food_valid, gf); end
    endtask
`endif

    task automatic test_busy_ignore();
        int de, ee, ex, ey; bit gf, ef, ho;
        rand_seq();
        fill_map(60);
        model_spawn(ee, ef, ex, ey);
        drive_spawn(1200, 1, de, gf, ho);
        checks++; if (de != ee || gf != ef || rd_q != exp_q) begin
            failures++; $display("FAIL busy_ignore edge=%0d fail=%0d strobes=%0d want %0d %0d %0d", de, gf, rd_q.size(), ee, ef, exp_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL busy_restart busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 64; i++) seq[i] = 9'h0A3;
        fill_map(100);
        @(negedge clk);
        n_fail_pulse = 0;
        spawn_req = 1'b1; rand_num = seq[0];
        @(posedge clk); #1 spawn_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || occ_rd !== 1'b0 || occ_addr !== 9'd0 || food_valid !== 1'b0 || food_x !== 5'd0 || food_y !== 4'd0) begin
            failures++; $display("FAIL reset_mid busy=%b occ_rd=%b v=%b x=%0d want all 0", busy, occ_rd, food_valid, food_x); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (n_fail_pulse != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_fail pulses=%0d busy=%b want 0,0", n_fail_pulse, busy); end
    endtask

    task automatic test_random();
        int de, ee, ex, ey, pct; bit gf, ef, ho;
        for (int n = 0; n < 30; n++) begin
            rand_seq();
            case ($urandom_range(0, 3))
                0: pct = 0;
                1: pct = 50;
                2: pct = 90;
                default: pct = 100;
            endcase
            fill_map(pct);
            model_spawn(ee, ef, ex, ey);
            drive_spawn(1200, 0, de, gf, ho);
            checks++; if (de != ee || gf != ef) begin
                failures++; $display("FAIL rand_outcome txn=%0d edge=%0d fail=%0d want %0d %0d", n, de, gf, ee, ef); end
            checks++; if (rd_q != exp_q) begin
                failures++; $display("FAIL rand_strobes txn=%0d got=%0d want=%0d", n, rd_q.size(), exp_q.size()); end
            checks++; if (!ho) begin
                failures++; $display("FAIL rand_hold txn=%0d food moved or busy dropped, want held", n); end
            if (!ef) begin
                checks++; if (food_x !== 5'(ex) || food_y !== 4'(ey) || food_valid !== 1'b1) begin
                    failures++; $display("FAIL rand_pos txn=%0d x=%0d y=%0d v=%b want %0d %0d 1", n, food_x, food_y, food_valid, ex, ey); end
            end else begin
                checks++; if (food_valid !== 1'b0) begin
                    failures++; $display("FAIL rand_failvalid txn=%0d v=%b want 0", n, food_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_protocol();
        checks++; if (prot_err != 0) begin
            failures++; $display("FAIL occ_protocol violations=%0d want 0", prot_err); end
    endtask

    initial begin
        test_reset();
        test_first_try();
        test_oob_retry();
        test_exhaust();
`ifdef FOOD_FALLBACK_SCAN_EN
        test_fallback();
`endif
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
